// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares the MMU request port among NUM_REQ requesters,
// with one outstanding transaction, a WAIT timeout and per-owner response routing.
module mem_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*32-1:0]      addr_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
  input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [MEM_W-1:0]           rdata_o,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  output logic                       mem_we_o,
  output logic [MEM_W/8-1:0]         mem_be_o,
  output logic [MEM_W-1:0]           mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [MEM_W-1:0]           mem_rdata_i,
  output logic                       busy_o,
  output logic [15:0]                timeout_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int BE_W  = MEM_W / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr, owner, win_idx, rr_next;
  logic             win_valid;
  logic [CNT_W-1:0] wait_cnt;
  logic             take_err, take_rvalid, take_timeout;

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    logic [PTR_W-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy_o  = (state != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    gnt_o        = '0;
    take_err     = 1'b0;
    take_rvalid  = 1'b0;
    take_timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (win_valid) begin
          gnt_o[win_idx] = 1'b1;
          state_next     = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // A response in the final counter cycle wins over the timeout.
        if (mem_err_i)                take_err     = 1'b1;
        else if (mem_rvalid_i)        take_rvalid  = 1'b1;
        else if (wait_cnt == CNT_LAST) take_timeout = 1'b1;
        if (take_err || take_rvalid || take_timeout) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: the datapath registers are reset too, since they drive outputs that must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      timeout_cnt_o <= '0;
      rvalid_o      <= '0;
      err_o         <= '0;
      rdata_o       <= '0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      mem_we_o      <= 1'b0;
      mem_be_o      <= '0;
      mem_wdata_o   <= '0;
    end else begin
      mem_req_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            mem_req_o   <= 1'b1;
            mem_addr_o  <= addr_i[int'(win_idx)*32 +: 32];
            mem_we_o    <= we_i[win_idx];
            mem_be_o    <= be_i[int'(win_idx)*BE_W +: BE_W];
            mem_wdata_o <= wdata_i[int'(win_idx)*MEM_W +: MEM_W];
            owner       <= win_idx;
            rr_ptr      <= rr_next;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (take_err || take_timeout) err_o[owner] <= 1'b1;
          if (take_rvalid) begin
            rvalid_o[owner] <= 1'b1;
            rdata_o         <= mem_rdata_i;
          end
          if (take_timeout && (timeout_cnt_o != 16'hFFFF))
            timeout_cnt_o <= timeout_cnt_o + 16'd1;
        end
        S_RESP: begin
          rvalid_o <= '0;
          err_o    <= '0;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory/peripheral request port of the MMU between NUM_REQ requesters: Ibex instruction fetch, Ibex data, and the Vicuna vector LSU.
- Selects one requester by round-robin and captures its request. Drives the MMU with a single-cycle request pulse, holds until the MMU responds or a timeout expires, then routes the response back to the owner.
- Allows exactly one outstanding transaction at a time.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is the highest priority after reset.
- MEM_W, 32, data bus width in bits; must match the MMU.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before an error is forced; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_i  in  NUM_REQ  per-requester request; held high until the matching gnt_o
- addr_i  in  NUM_REQ*32  packed addresses; requester r uses bits [r*32 +: 32]
- we_i  in  NUM_REQ  write enable per requester
- be_i  in  NUM_REQ*MEM_W/8  packed byte enables
- wdata_i  in  NUM_REQ*MEM_W  packed write data
- gnt_o  out  NUM_REQ  one-hot grant; combinational, asserted in IDLE only
- rvalid_o  out  NUM_REQ  one-hot response valid, registered
- err_o  out  NUM_REQ  one-hot response error, registered
- rdata_o  out  MEM_W  response data, shared by all requesters; valid only with rvalid_o
- mem_req_o  out  1  request to the MMU
- mem_addr_o  out  32  address to the MMU
- mem_we_o  out  1  write enable to the MMU
- mem_be_o  out  MEM_W/8  byte enables to the MMU
- mem_wdata_o  out  MEM_W  write data to the MMU
- mem_rvalid_i  in  1  MMU response valid
- mem_err_i  in  1  MMU response error
- mem_rdata_i  in  MEM_W  MMU read data
- busy_o  out  1  high whenever the state is not IDLE
- timeout_cnt_o  out  16  saturating count of forced timeouts

Behaviour:
- Reset (rst==0 at a posedge):
  - state=IDLE, rr_ptr=0, owner=0, wait counter=0, timeout_cnt_o=0.
  - All registered outputs go to 0: rvalid_o, err_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o.
  - Reset mid-transaction discards the transaction: no response is delivered; late MMU responses are ignored in IDLE.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_i bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - gnt_o[winner]=1 in the same cycle.
  - At that edge: capture winner's addr/we/be/wdata into the mem_* registers; owner=winner; rr_ptr=(winner+1) mod NUM_REQ; go to ISSUE.
  - With no request, gnt_o=0 and the state is held.
- ISSUE: mem_req_o=1 for exactly this one cycle, with the captured values stable. Go to WAIT. MMU response inputs are not sampled in this cycle.
- WAIT:
  - mem_req_o=0; mem_* address/data registers hold their values.
  - The counter increments every cycle.
  - If mem_err_i: err_o[owner]<=1, go to RESP.
  - Else if mem_rvalid_i: rvalid_o[owner]<=1, rdata_o<=mem_rdata_i, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: err_o[owner]<=1, timeout_cnt_o increments (saturating at 0xFFFF), go to RESP.
- Priority in WAIT: err > rvalid > timeout. A response arriving in the same cycle the counter expires counts as a normal response; no timeout is recorded.
- mem_err_i and mem_rvalid_i together: only err_o is asserted; rdata_o is unchanged.
- RESP:
  - The single-cycle response pulse is visible on rvalid_o/err_o.
  - At the next edge rvalid_o and err_o clear, the counter clears, and the state goes to IDLE.
  - rdata_o holds its last value.
- Latency: grant at cycle T, mem_req_o at T+1. An MMU response at T+1+k (k ≥ 1) appears on rvalid_o/err_o at T+2+k. Minimum grant-to-grant spacing is 4 cycles.
- Writes complete on mem_rvalid_i like reads. A write the MMU never acknowledges completes via timeout with err_o.
- Fairness: a requester holding req_i high is granted within NUM_REQ transactions.
- A req_i dropped before grant is legal and is ignored. Requests that change while not in IDLE have no effect.

Test Plan:
- Reset, then req_i=3'b001, addr=0x1000, read; MMU rvalid 3 cycles after mem_req_o with rdata 0xDEADBEEF -> gnt_o=001 at T; mem_req_o=1 only at T+1 with addr 0x1000; rvalid_o=001 and rdata_o=0xDEADBEEF at T+5.
- req_i=3'b111 held continuously, MMU acknowledging every request -> grant order 0,1,2,0,1,2; exactly one gnt_o bit per grant; grants spaced ≥ 4 cycles.
- Requester 2 write to 0x0115 with wdata=0x64, MMU never responds, TIMEOUT_CYCLES=8 -> err_o=100 exactly 8 cycles after WAIT entry; timeout_cnt_o=1; next grant is accepted normally.
- MMU asserts mem_rvalid_i and mem_err_i in the same cycle for a requester 1 read -> err_o=010, rvalid_o=000, rdata_o unchanged.
- rst pulled low while in WAIT for requester 0, then the MMU rvalid arrives after reset releases -> no rvalid_o or err_o pulse; gnt_o=0 until a new req_i; rr_ptr restarts at 0.
- MMU response arrives in exactly the final timeout cycle -> rvalid_o pulses with the read data; timeout_cnt_o unchanged.
